// File: rtl/doodle_jump_engine_if.sv
// Bundle of the engine's control inputs and the position/score/state outputs.
// The master side drives the controls; the slave side is the engine itself.
interface doodle_jump_engine_if #(
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned NUM_PLAT = 4,
    parameter int unsigned SCORE_W  = 16
);
    logic                         Start;
    logic                         Ack;
    logic                         Tick;
    logic                         Left;
    logic                         Right;
    logic [COORD_W-1:0]           rand_x;
    logic [COORD_W-1:0]           doodle_x;
    logic [COORD_W-1:0]           doodle_y;
    logic [NUM_PLAT*COORD_W-1:0]  plat_x;
    logic [NUM_PLAT*COORD_W-1:0]  plat_y;
    logic [SCORE_W-1:0]           score;
    logic                         q_I;
    logic                         q_Up;
    logic                         q_Down;
    logic                         q_Done;

    modport master (
        output Start, Ack, Tick, Left, Right, rand_x,
        input  doodle_x, doodle_y, plat_x, plat_y, score, q_I, q_Up, q_Down, q_Done
    );

    modport slave (
        input  Start, Ack, Tick, Left, Right, rand_x,
        output doodle_x, doodle_y, plat_x, plat_y, score, q_I, q_Up, q_Down, q_Done
    );
endinterface

// File: rtl/doodle_jump_engine.sv
// Tick-paced vertical game physics: doodle position, platforms, landing, camera
// scroll, platform respawn, horizontal wrap, score and game-over.
module doodle_jump_engine #(
    parameter int unsigned H_RES    = 640,
    parameter int unsigned V_RES    = 480,
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned NUM_PLAT = 4,
    parameter int unsigned JUMP_H   = 120,
    parameter int unsigned STEP     = 2,
    parameter int unsigned HSTEP    = 4,
    parameter int unsigned SCROLL_Y = 200,
    parameter int unsigned DOODLE_W = 20,
    parameter int unsigned DOODLE_H = 20,
    parameter int unsigned PLAT_W   = 40,
    parameter int unsigned SCORE_W  = 16
) (
    input logic                  Clk,
    input logic                  Reset,
    doodle_jump_engine_if.slave  bus
);
    typedef enum logic [1:0] {StI, StUp, StDown, StDone} state_e;

    localparam int unsigned RISE_W = $clog2(JUMP_H + STEP + 1);
    localparam int unsigned W1     = COORD_W + 1;
    localparam int unsigned W2     = COORD_W + 2;
    localparam int unsigned SW1    = SCORE_W + 1;

    localparam logic [COORD_W-1:0] XMAX  = COORD_W'(H_RES - PLAT_W);
    localparam logic [COORD_W-1:0] DXMAX = COORD_W'(H_RES - DOODLE_W);
    localparam logic [COORD_W-1:0] DX0   = COORD_W'(H_RES / 2 - DOODLE_W / 2);
    localparam logic [COORD_W-1:0] DY0   = COORD_W'(V_RES - 40 - DOODLE_H);

    function automatic logic [COORD_W-1:0] clampx(input logic [COORD_W-1:0] v);
        return (v > XMAX) ? XMAX : v;
    endfunction

    function automatic logic [COORD_W-1:0] plat_x0(input int unsigned k);
        return (k == 0) ? COORD_W'(H_RES / 2 - PLAT_W / 2) : COORD_W'(k * (H_RES / NUM_PLAT));
    endfunction

    function automatic logic [COORD_W-1:0] plat_y0(input int unsigned k);
        return COORD_W'(V_RES - 40 - k * (V_RES / NUM_PLAT));
    endfunction

    state_e              state_q, state_d;
    logic [COORD_W-1:0]  dx_q, dx_d, dy_q, dy_d;
    logic [COORD_W-1:0]  px_q [NUM_PLAT];
    logic [COORD_W-1:0]  px_d [NUM_PLAT];
    logic [COORD_W-1:0]  py_q [NUM_PLAT];
    logic [COORD_W-1:0]  py_d [NUM_PLAT];
    logic [SCORE_W-1:0]  score_q, score_d;
    logic [RISE_W-1:0]   rise_q, rise_d;

    logic [COORD_W-1:0]  hx;
    logic [W1-1:0]       dx_right;
    logic [W2-1:0]       bottom;
    logic                land_hit;
    logic [COORD_W-1:0]  land_y;
    logic [SW1-1:0]      score_sum;
    logic                go_home;
    logic                scatter;

    assign dx_right  = {1'b0, dx_q} + W1'(HSTEP);
    assign score_sum = {1'b0, score_q} + SW1'(STEP);

    // Horizontal candidate position with wrap; both or neither key holds x.
    always_comb begin
        hx = dx_q;
        if (bus.Left && !bus.Right) begin
            hx = (dx_q < COORD_W'(HSTEP)) ? DXMAX : dx_q - COORD_W'(HSTEP);
        end else if (bus.Right && !bus.Left) begin
            hx = (dx_right > {1'b0, DXMAX}) ? '0 : dx_right[COORD_W-1:0];
        end
    end

    // Landing search against the post-move x; lowest platform index wins.
    always_comb begin
        land_hit = 1'b0;
        land_y   = '0;
        bottom   = {2'b00, dy_q} + W2'(DOODLE_H);
        for (int unsigned k = 0; k < NUM_PLAT; k++) begin
            if (!land_hit &&
                bottom <= {2'b00, py_q[k]} &&
                bottom + W2'(STEP) >= {2'b00, py_q[k]} &&
                {2'b00, hx} + W2'(DOODLE_W) > {2'b00, px_q[k]} &&
                {2'b00, hx} < {2'b00, px_q[k]} + W2'(PLAT_W)) begin
                land_hit = 1'b1;
                land_y   = py_q[k] - COORD_W'(DOODLE_H);
            end
        end
    end

    // Next-state and next-world computation.
    always_comb begin
        state_d = state_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        px_d    = px_q;
        py_d    = py_q;
        score_d = score_q;
        rise_d  = rise_q;
        go_home = 1'b0;
        scatter = 1'b0;

        case (state_q)
            StI: begin
                if (bus.Start) begin
                    state_d = StUp;
                    go_home = 1'b1;
                    scatter = 1'b1;
                end
            end
            StUp: begin
                if (bus.Tick) begin
                    dx_d   = hx;
                    rise_d = rise_q + RISE_W'(STEP);
                    // Doodle pinned at the scroll line: move the world down instead.
                    if ({2'b00, dy_q} < W2'(SCROLL_Y + STEP)) begin
                        for (int unsigned k = 0; k < NUM_PLAT; k++) begin
                            py_d[k] = py_q[k] + COORD_W'(STEP);
                        end
                        score_d = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
                    end else begin
                        dy_d = dy_q - COORD_W'(STEP);
                    end
                    for (int unsigned k = 0; k < NUM_PLAT; k++) begin
                        if (py_d[k] >= COORD_W'(V_RES)) begin
                            py_d[k] = '0;
                            px_d[k] = clampx(bus.rand_x);
                        end
                    end
                    if (rise_d >= RISE_W'(JUMP_H)) begin
                        state_d = StDown;
                    end
                end
            end
            StDown: begin
                if (bus.Tick) begin
                    dx_d = hx;
                    if (land_hit) begin
                        dy_d    = land_y;
                        rise_d  = '0;
                        state_d = StUp;
                    end else begin
                        dy_d = dy_q + COORD_W'(STEP);
                        if ({2'b00, dy_q} + W2'(STEP + DOODLE_H) >= W2'(V_RES)) begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                if (bus.Ack) begin
                    state_d = StI;
                    go_home = 1'b1;
                end
            end
            default: begin
                state_d = StI;
                go_home = 1'b1;
            end
        endcase

        if (go_home) begin
            dx_d    = DX0;
            dy_d    = DY0;
            score_d = '0;
            rise_d  = '0;
            for (int unsigned k = 0; k < NUM_PLAT; k++) begin
                px_d[k] = plat_x0(k);
                py_d[k] = plat_y0(k);
            end
        end
        // New game: spread the upper platforms around a random offset.
        if (scatter) begin
            for (int unsigned k = 1; k < NUM_PLAT; k++) begin
                px_d[k] = clampx(COORD_W'((32'(bus.rand_x) + k * (H_RES / NUM_PLAT)) % H_RES));
            end
        end
    end

    // State and world registers with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StI;
            dx_q    <= DX0;
            dy_q    <= DY0;
            score_q <= '0;
            rise_q  <= '0;
            for (int unsigned k = 0; k < NUM_PLAT; k++) begin
                px_q[k] <= plat_x0(k);
                py_q[k] <= plat_y0(k);
            end
        end else begin
            state_q <= state_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            score_q <= score_d;
            rise_q  <= rise_d;
            px_q    <= px_d;
            py_q    <= py_d;
        end
    end

    assign bus.doodle_x = dx_q;
    assign bus.doodle_y = dy_q;
    assign bus.score    = score_q;
    assign bus.q_I      = (state_q == StI);
    assign bus.q_Up     = (state_q == StUp);
    assign bus.q_Down   = (state_q == StDown);
    assign bus.q_Done   = (state_q == StDone);

    for (genvar k = 0; k < NUM_PLAT; k++) begin : g_pack
        assign bus.plat_x[k*COORD_W +: COORD_W] = px_q[k];
        assign bus.plat_y[k*COORD_W +: COORD_W] = py_q[k];
    end
endmodule

// File: tb/tb_doodle_jump_engine.sv
// Self-checking bench: directed scenarios plus a randomized run, compared against
// an integer game model. A second engine with a tall jump covers scrolling.
module tb_doodle_jump_engine;
    localparam int NP = 4;
    localparam int CW = 10;
    localparam int SW = 16;
    localparam int MI = 0, MU = 1, MD = 2, MX = 3;

    logic Clk = 1'b0;
    logic Reset;
    logic start, ack, tick, left, right;
    logic [CW-1:0] rand_x;

    always #5 Clk = ~Clk;

    doodle_jump_engine_if #(.COORD_W(CW), .NUM_PLAT(NP), .SCORE_W(SW)) ifa ();
    doodle_jump_engine_if #(.COORD_W(CW), .NUM_PLAT(NP), .SCORE_W(SW)) ifb ();

    assign ifa.Start = start;  assign ifb.Start = start;
    assign ifa.Ack = ack;      assign ifb.Ack = ack;
    assign ifa.Tick = tick;    assign ifb.Tick = tick;
    assign ifa.Left = left;    assign ifb.Left = left;
    assign ifa.Right = right;  assign ifb.Right = right;
    assign ifa.rand_x = rand_x; assign ifb.rand_x = rand_x;

    doodle_jump_engine dut_a (.Clk(Clk), .Reset(Reset), .bus(ifa));
    doodle_jump_engine #(.JUMP_H(300)) dut_b (.Clk(Clk), .Reset(Reset), .bus(ifb));

    int n_total = 0;
    int n_pass  = 0;

    // Reference model of engine A in plain integers.
    int m_st, m_dx, m_dy, m_score, m_rise;
    int m_px [NP];
    int m_py [NP];

    function automatic int clampx(input int v);
        return (v > 600) ? 600 : v;
    endfunction

    task automatic model_reset();
        m_st = MI; m_dx = 310; m_dy = 420; m_score = 0; m_rise = 0;
        m_px[0] = 300; m_py[0] = 440;
        for (int k = 1; k < NP; k++) begin
            m_px[k] = k * (640 / NP);
            m_py[k] = 440 - k * (480 / NP);
        end
    endtask

    task automatic model_step();
        int land;
        if (Reset) begin
            model_reset();
            return;
        end
        case (m_st)
            MI: if (start) begin
                model_reset();
                for (int k = 1; k < NP; k++) m_px[k] = clampx((int'(rand_x) + k * 160) % 640);
                m_st = MU;
            end
            MU, MD: if (tick) begin
                if (left && !right) m_dx = (m_dx < 4) ? 620 : m_dx - 4;
                else if (right && !left) m_dx = (m_dx + 4 > 620) ? 0 : m_dx + 4;
                if (m_st == MU) begin
                    m_rise += 2;
                    if (m_dy - 2 < 200) begin
                        for (int k = 0; k < NP; k++) m_py[k] += 2;
                        m_score = (m_score + 2 > 65535) ? 65535 : m_score + 2;
                    end else begin
                        m_dy -= 2;
                    end
                    for (int k = 0; k < NP; k++) begin
                        if (m_py[k] >= 480) begin
                            m_py[k] = 0;
                            m_px[k] = clampx(int'(rand_x));
                        end
                    end
                    if (m_rise >= 120) m_st = MD;
                end else begin
                    land = -1;
                    for (int k = 0; k < NP; k++) begin
                        if (land < 0 && m_dy + 20 <= m_py[k] && m_dy + 22 >= m_py[k] &&
                            m_dx + 20 > m_px[k] && m_dx < m_px[k] + 40) land = k;
                    end
                    if (land >= 0) begin
                        m_dy = m_py[land] - 20;
                        m_rise = 0;
                        m_st = MU;
                    end else begin
                        m_dy += 2;
                        if (m_dy + 20 >= 480) m_st = MX;
                    end
                end
            end
            default: if (ack) model_reset();
        endcase
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("check %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [NP*CW-1:0] epx, epy;
        for (int k = 0; k < NP; k++) begin
            epx[k*CW +: CW] = CW'(m_px[k]);
            epy[k*CW +: CW] = CW'(m_py[k]);
        end
        check("m_q_I", 64'(ifa.q_I), 64'(m_st == MI));
        check("m_q_Up", 64'(ifa.q_Up), 64'(m_st == MU));
        check("m_q_Down", 64'(ifa.q_Down), 64'(m_st == MD));
        check("m_q_Done", 64'(ifa.q_Done), 64'(m_st == MX));
        check("m_doodle_x", 64'(ifa.doodle_x), 64'(m_dx));
        check("m_doodle_y", 64'(ifa.doodle_y), 64'(m_dy));
        check("m_plat_x", 64'(ifa.plat_x), 64'(epx));
        check("m_plat_y", 64'(ifa.plat_y), 64'(epy));
        check("m_score", 64'(ifa.score), 64'(m_score));
    endtask

    task automatic cyc();
        @(posedge Clk);
        model_step();
        #1;
        check_model();
    endtask

    // Each frame: one Tick cycle followed by one idle cycle.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1; cyc();
            tick = 1'b0; cyc();
        end
    endtask

    task automatic check_home(input string tag, input logic [CW-1:0] x, input logic [CW-1:0] y,
                              input logic [NP*CW-1:0] px, input logic [NP*CW-1:0] py,
                              input logic [SW-1:0] sc, input logic qi);
        logic [NP*CW-1:0] hpx, hpy;
        hpx = {10'd480, 10'd320, 10'd160, 10'd300};
        hpy = {10'd80, 10'd200, 10'd320, 10'd440};
        check({tag, "_q_I"}, 64'(qi), 64'd1);
        check({tag, "_x"}, 64'(x), 64'd310);
        check({tag, "_y"}, 64'(y), 64'd420);
        check({tag, "_plat_x"}, 64'(px), 64'(hpx));
        check({tag, "_plat_y"}, 64'(py), 64'(hpy));
        check({tag, "_score"}, 64'(sc), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] fx, fy;
        logic [NP*CW-1:0] fpx, fpy;
        Reset = 1'b1; start = 1'b0; ack = 1'b0; tick = 1'b0;
        left = 1'b0; right = 1'b0; rand_x = '0;
        model_reset();

        // Reset and idle Ticks in I.
        repeat (5) cyc();
        Reset = 1'b0;
        check_home("rst", ifa.doodle_x, ifa.doodle_y, ifa.plat_x, ifa.plat_y, ifa.score, ifa.q_I);
        ticks(3);
        check_home("idle", ifa.doodle_x, ifa.doodle_y, ifa.plat_x, ifa.plat_y, ifa.score, ifa.q_I);

        // Single jump then landing back on platform 0.
        rand_x = '0; start = 1'b1; cyc(); start = 1'b0;
        check("start_up", 64'(ifa.q_Up), 64'd1);
        ticks(60);
        check("apex_y", 64'(ifa.doodle_y), 64'd300);
        check("apex_down", 64'(ifa.q_Down), 64'd1);
        ticks(60);
        check("land_y", 64'(ifa.doodle_y), 64'd420);
        check("land_up", 64'(ifa.q_Up), 64'd1);
        check("land_score", 64'(ifa.score), 64'd0);

        // Horizontal wrap both ways and the both-keys hold.
        left = 1'b1; ticks(77);
        check("walk_x", 64'(ifa.doodle_x), 64'd2);
        ticks(1);
        check("wrap_left", 64'(ifa.doodle_x), 64'd620);
        left = 1'b0; right = 1'b1; ticks(1);
        check("wrap_right", 64'(ifa.doodle_x), 64'd0);
        left = 1'b1; ticks(1);
        check("both_hold", 64'(ifa.doodle_x), 64'd0);
        left = 1'b0; right = 1'b0;

        // Miss platform 0, fall to the bottom, freeze, then Ack.
        Reset = 1'b1; cyc(); Reset = 1'b0;
        rand_x = '0; start = 1'b1; cyc(); start = 1'b0;
        right = 1'b1; ticks(20); right = 1'b0;
        ticks(40);
        for (int i = 0; i < 200 && !ifa.q_Done; i++) ticks(1);
        check("done_q", 64'(ifa.q_Done), 64'd1);
        check("done_x", 64'(ifa.doodle_x), 64'd390);
        check("done_y", 64'(ifa.doodle_y), 64'd460);
        fx = ifa.doodle_x; fy = ifa.doodle_y; fpx = ifa.plat_x; fpy = ifa.plat_y;
        left = 1'b1; start = 1'b1; ticks(10); left = 1'b0; start = 1'b0;
        check("frz_q", 64'(ifa.q_Done), 64'd1);
        check("frz_x", 64'(ifa.doodle_x), 64'(fx));
        check("frz_y", 64'(ifa.doodle_y), 64'(fy));
        check("frz_px", 64'(ifa.plat_x), 64'(fpx));
        check("frz_py", 64'(ifa.plat_y), 64'(fpy));
        ack = 1'b1; cyc(); ack = 1'b0;
        check_home("ack", ifa.doodle_x, ifa.doodle_y, ifa.plat_x, ifa.plat_y, ifa.score, ifa.q_I);

        // Reset in the middle of a fall.
        rand_x = 10'd77; start = 1'b1; cyc(); start = 1'b0;
        ticks(85);
        check("mid_y", 64'(ifa.doodle_y), 64'd350);
        check("mid_down", 64'(ifa.q_Down), 64'd1);
        Reset = 1'b1; cyc(); Reset = 1'b0;
        check_home("midrst", ifa.doodle_x, ifa.doodle_y, ifa.plat_x, ifa.plat_y, ifa.score,
                   ifa.q_I);

        // Tall jump on engine B: pin at the scroll line, scroll, respawn.
        rand_x = 10'd1000; start = 1'b1; cyc(); start = 1'b0;
        for (int t = 1; t <= 150; t++) begin
            ticks(1);
            if (t == 110) check("b_pin_y", 64'(ifb.doodle_y), 64'd200);
            if (t == 111) begin
                check("b_hold_y", 64'(ifb.doodle_y), 64'd200);
                check("b_score1", 64'(ifb.score), 64'd2);
            end
            if (t == 130) begin
                check("b_resp_x", 64'(ifb.plat_x[CW-1:0]), 64'd600);
                check("b_resp_y", 64'(ifb.plat_y[CW-1:0]), 64'd0);
            end
        end
        check("b_score", 64'(ifb.score), 64'd80);
        check("b_down", 64'(ifb.q_Down), 64'd1);

        // Randomized play against the model.
        for (int i = 0; i < 4000; i++) begin
            rand_x = CW'($urandom_range(0, 1023));
            tick   = ($urandom_range(0, 2) != 0);
            left   = ($urandom_range(0, 3) == 0);
            right  = ($urandom_range(0, 3) == 0);
            start  = ($urandom_range(0, 9) == 0);
            ack    = ($urandom_range(0, 9) == 0);
            Reset  = ($urandom_range(0, 999) == 0);
            cyc();
        end
        Reset = 1'b0; start = 1'b0; ack = 1'b0; tick = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
